regfile_wb_arbiter: RTL and testbench

//  Shares the single register-file write port between two writeback requesters:
//  ALU results (port A) and memory/load results (port B).

---
 rtl/regfile_wb_arbiter.sv | 144 ++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter that merges two writeback streams, each buffered by a small FIFO,
// onto one registered register-file write port. Define RF_WB_SCOREBOARD_EN to add `pending`.
module regfile_wb_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned FIFO_D = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  input  logic              wr_stall,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              idle
`ifdef RF_WB_SCOREBOARD_EN
  ,
  output logic [(2**ADDR_W)-1:0] pending
`endif
);

  localparam int unsigned PW = $clog2(FIFO_D);
  localparam logic [PW:0] PtrOne = (PW + 1)'(1);

  typedef enum logic {PortA = 1'b0, PortB = 1'b1} port_e;

  // Index 0 is port A, index 1 is port B.
  logic [ADDR_W-1:0] q_addr [2][FIFO_D];
  logic [DATA_W-1:0] q_data [2][FIFO_D];
  logic [PW:0]       wptr_q [2];
  logic [PW:0]       rptr_q [2];
  logic [ADDR_W-1:0] in_addr [2];
  logic [DATA_W-1:0] in_data [2];
  logic [1:0]        full;
  logic [1:0]        empty;
  logic [1:0]        push;
  logic [1:0]        pop;
  logic              contended;
  logic              sel;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  port_e             rr_last_q;

  always_comb begin
    in_addr[0] = a_addr;
    in_addr[1] = b_addr;
    in_data[0] = a_data;
    in_data[1] = b_data;
    for (int p = 0; p < 2; p++) begin
      full[p]  = (wptr_q[p][PW] != rptr_q[p][PW]) &&
                 (wptr_q[p][PW-1:0] == rptr_q[p][PW-1:0]);
      empty[p] = (wptr_q[p] == rptr_q[p]);
    end
  end

  // Ready is forced low during reset so nothing is accepted while state is being cleared.
  assign a_ready = !rst && !full[0];
  assign b_ready = !rst && !full[1];
  assign push[0] = a_valid && a_ready;
  assign push[1] = b_valid && b_ready;

  always_comb begin
    pop       = 2'b00;
    contended = !empty[0] && !empty[1];
    if (!rst && !wr_stall) begin
      if (contended) begin
        if (rr_last_q == PortB) pop[0] = 1'b1;
        else                    pop[1] = 1'b1;
      end else if (!empty[0]) begin
        pop[0] = 1'b1;
      end else if (!empty[1]) begin
        pop[1] = 1'b1;
      end
    end
  end

  always_comb begin
    sel       = pop[1];
    head_addr = q_addr[sel][rptr_q[sel][PW-1:0]];
    head_data = q_data[sel][rptr_q[sel][PW-1:0]];
  end

  // Storage needs no reset; pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (push[p]) begin
        q_addr[p][wptr_q[p][PW-1:0]] <= in_addr[p];
        q_data[p][wptr_q[p][PW-1:0]] <= in_data[p];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < 2; p++) begin
        wptr_q[p] <= '0;
        rptr_q[p] <= '0;
      end
      rr_last_q <= PortB;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (push[p]) wptr_q[p] <= wptr_q[p] + PtrOne;
        if (pop[p])  rptr_q[p] <= rptr_q[p] + PtrOne;
      end
      if (contended && (pop != 2'b00)) rr_last_q <= pop[0] ? PortA : PortB;
      // Address-0 entries are consumed but never strobed into the register file.
      wr_en <= (pop != 2'b00) && (head_addr != '0);
      if (pop != 2'b00) begin
        wr_addr <= head_addr;
        wr_data <= head_data;
      end
    end
  end

  assign idle = empty[0] && empty[1] && !wr_en;

`ifdef RF_WB_SCOREBOARD_EN
  always_comb begin : sb
    logic [PW-1:0] off;
    logic [PW:0]   cnt;
    pending = '0;
    for (int p = 0; p < 2; p++) begin
      cnt = wptr_q[p] - rptr_q[p];
      for (int i = 0; i < FIFO_D; i++) begin
        off = PW'(i) - rptr_q[p][PW-1:0];
        if ({1'b0, off} < cnt) pending[q_addr[p][i]] = 1'b1;
      end
    end
    if (wr_en) pending[wr_addr] = 1'b1;
    pending[0] = 1'b0;
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: vector table for the main flow, hand sequences
// for reset and mid-operation reset.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid, a_ready, b_ready;
  logic [4:0]  a_addr, b_addr, wr_addr;
  logic [31:0] a_data, b_data, wr_data;
  logic        wr_stall, wr_en, idle;
`ifdef RF_WB_SCOREBOARD_EN
  logic [31:0] pending;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(
    .DATA_W(32),
    .ADDR_W(5),
    .FIFO_D(2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .a_valid (a_valid),
    .a_ready (a_ready),
    .a_addr  (a_addr),
    .a_data  (a_data),
    .b_valid (b_valid),
    .b_ready (b_ready),
    .b_addr  (b_addr),
    .b_data  (b_data),
    .wr_stall(wr_stall),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .idle    (idle)
`ifdef RF_WB_SCOREBOARD_EN
    ,
    .pending (pending)
`endif
  );

  typedef struct {
    logic        av;
    logic [4:0]  aa;
    logic [31:0] ad;
    logic        bv;
    logic [4:0]  ba;
    logic [31:0] bd;
    logic        st;
    logic        e_ar;
    logic        e_br;
    logic        e_we;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    logic        e_idle;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                              input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                              input logic st, input logic ar, input logic br,
                              input logic we, input logic [4:0] wa, input logic [31:0] wd,
                              input logic idl);
    vec_t v;
    v.av = av; v.aa = aa; v.ad = ad;
    v.bv = bv; v.ba = ba; v.bd = bd;
    v.st = st;
    v.e_ar = ar; v.e_br = br; v.e_we = we; v.e_wa = wa; v.e_wd = wd; v.e_idle = idl;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_valid = 1'b0; a_addr = '0; a_data = '0;
    b_valid = 1'b0; b_addr = '0; b_data = '0;
    wr_stall = 1'b0;
  endtask

  initial begin
    // Single write, then a dropped address-0 write on B.
    tbl.push_back(mk(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 1, 1, 0, 0, 32'h0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 5, 32'hDEADBEEF, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 5, 32'hDEADBEEF, 1));
    tbl.push_back(mk(0, 0, 0, 1, 0, 32'h1234, 0, 1, 1, 0, 5, 32'hDEADBEEF, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 32'h1234, 1));
    // Contention: 4 entries per port; sources hold data while ready is low.
    tbl.push_back(mk(1, 1, 32'hA0000001, 1, 11, 32'hB0000001, 0, 1, 1, 0, 0, 32'h1234, 0));
    tbl.push_back(mk(1, 2, 32'hA0000002, 1, 12, 32'hB0000002, 0, 1, 0, 1, 1, 32'hA0000001, 0));
    tbl.push_back(mk(1, 3, 32'hA0000003, 1, 13, 32'hB0000003, 0, 0, 1, 1, 11, 32'hB0000001, 0));
    tbl.push_back(mk(1, 4, 32'hA0000004, 1, 13, 32'hB0000003, 0, 1, 0, 1, 2, 32'hA0000002, 0));
    tbl.push_back(mk(1, 4, 32'hA0000004, 1, 14, 32'hB0000004, 0, 0, 1, 1, 12, 32'hB0000002, 0));
    tbl.push_back(mk(0, 0, 0, 1, 14, 32'hB0000004, 0, 1, 0, 1, 3, 32'hA0000003, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 13, 32'hB0000003, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 4, 32'hA0000004, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 14, 32'hB0000004, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 14, 32'hB0000004, 1));
    // Stall: fill both FIFOs under 5 stalled cycles, then drain B,A,B,A (rr_last is A).
    tbl.push_back(mk(1, 6, 32'h66, 1, 16, 32'h1616, 1, 1, 1, 0, 14, 32'hB0000004, 0));
    tbl.push_back(mk(1, 7, 32'h77, 1, 17, 32'h1717, 1, 0, 0, 0, 14, 32'hB0000004, 0));
    tbl.push_back(mk(1, 8, 32'h88, 1, 18, 32'h1818, 1, 0, 0, 0, 14, 32'hB0000004, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 14, 32'hB0000004, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 14, 32'hB0000004, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 16, 32'h1616, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 6, 32'h66, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 17, 32'h1717, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 7, 32'h77, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 7, 32'h77, 1));

    // Reset held 3 cycles with a_valid asserted.
    idle_inputs();
    rst = 1'b1;
    a_valid = 1'b1; a_addr = 5'd9; a_data = 32'h99;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("rst%0d a_ready", i), a_ready, 1'b0);
      chk($sformatf("rst%0d b_ready", i), b_ready, 1'b0);
      chk($sformatf("rst%0d wr_en", i), wr_en, 1'b0);
      chk($sformatf("rst%0d idle", i), idle, 1'b1);
    end
    rst = 1'b0;
    a_valid = 1'b0;
    #1;
    chk("post_rst a_ready", a_ready, 1'b1);
    chk("post_rst b_ready", b_ready, 1'b1);
    chk("post_rst wr_addr", wr_addr, 5'd0);
    chk("post_rst wr_data", wr_data, 32'h0);

    foreach (tbl[i]) begin
      a_valid = tbl[i].av; a_addr = tbl[i].aa; a_data = tbl[i].ad;
      b_valid = tbl[i].bv; b_addr = tbl[i].ba; b_data = tbl[i].bd;
      wr_stall = tbl[i].st;
      step();
      chk($sformatf("vec%0d a_ready", i), a_ready, tbl[i].e_ar);
      chk($sformatf("vec%0d b_ready", i), b_ready, tbl[i].e_br);
      chk($sformatf("vec%0d wr_en", i), wr_en, tbl[i].e_we);
      chk($sformatf("vec%0d wr_addr", i), wr_addr, tbl[i].e_wa);
      chk($sformatf("vec%0d wr_data", i), wr_data, tbl[i].e_wd);
      chk($sformatf("vec%0d idle", i), idle, tbl[i].e_idle);
    end

    // Mid-operation reset with three entries queued behind a stall.
    idle_inputs();
    wr_stall = 1'b1;
    a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h33;
    step();
    a_addr = 5'd4; a_data = 32'h44;
    b_valid = 1'b1; b_addr = 5'd9; b_data = 32'h99;
    step();
    a_valid = 1'b0; b_valid = 1'b0;
    chk("midrst queued wr_en", wr_en, 1'b0);
    chk("midrst queued idle", idle, 1'b0);
`ifdef RF_WB_SCOREBOARD_EN
    chk("midrst pending before", pending, 32'h0000_0218);
`endif
    wr_stall = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst a_ready in rst", a_ready, 1'b0);
    step();
    chk("midrst wr_en in rst", wr_en, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("midrst%0d wr_en", i), wr_en, 1'b0);
      chk($sformatf("midrst%0d idle", i), idle, 1'b1);
`ifdef RF_WB_SCOREBOARD_EN
      chk($sformatf("midrst%0d pending", i), pending, 32'h0);
`endif
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
